cpu_run_controller: RTL and testbench

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/run_rate_divider.sv | 46 ++++
 rtl/cpu_run_controller.sv | 144 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU run controller, the CPU top and the display
// logic: run-state encodings, request bundle, command resolution.
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int PC_W       = 3;
    localparam int STEP_CNT_W = 8;

    // Encodings are visible on the state port and decoded by the display.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } run_state_e;

    // Single resolved command per clk after priority arbitration.
    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_STEP = 2'b01,
        CMD_RUN  = 2'b10,
        CMD_HALT = 2'b11
    } run_cmd_e;

    typedef struct packed {
        logic halt;
        logic run;
        logic step;
    } run_req_t;

    // halt beats run beats step when pulses coincide.
    function automatic run_cmd_e resolve_cmd(input run_req_t req);
        run_cmd_e cmd;
        if (req.halt)      cmd = CMD_HALT;
        else if (req.run)  cmd = CMD_RUN;
        else if (req.step) cmd = CMD_STEP;
        else               cmd = CMD_NONE;
        return cmd;
    endfunction

endpackage

// File: rtl/run_rate_divider.sv
// ----------------------------------------------------------------------------
// run_rate_divider
// Tick-driven down counter that paces RUN mode. Loaded with rate, decremented
// on each enabled tick, and reloaded with rate when a tick lands on zero, so a
// step is due every (rate + 1) ticks.
//
// Ports:
//   clk, reset_n : clock, async active-low reset (count clears to 0)
//   load         : load count from rate (takes precedence over tick_en)
//   tick_en      : tick qualified by the caller (only while running)
//   rate         : reload value, sampled only on load/reload
//   expire       : combinational, tick_en while count is zero (step due)
// ----------------------------------------------------------------------------
module run_rate_divider #(
    parameter int DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                tick_en,
    input  logic [DIV_BITS-1:0] rate,
    output logic                expire
);

    localparam logic [DIV_BITS-1:0] ONE = DIV_BITS'(1);

    logic [DIV_BITS-1:0] count_d, count_q;
    logic                zero;

    assign zero   = (count_q == '0);
    assign expire = tick_en && zero;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = rate;
        else if (tick_en)
            count_d = zero ? rate : count_q - ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

endmodule

// File: rtl/cpu_run_controller.sv
// ----------------------------------------------------------------------------
// cpu_run_controller
// Single-step / free-run / breakpoint controller for a small CPU. Issues
// one-clk cpu_step pulses either on request (STEP) or paced by tick through a
// rate divider (RUN), and stops RUN when the stepped PC hits a breakpoint.
//
// Ports:
//   clk, reset_n      : 1 MHz clock, async active-low reset
//   tick              : 1 kHz enable pulse, paces RUN
//   step_req/run_req/halt_req : one-clk request pulses (halt > run > step)
//   rate [DIV_BITS]   : ticks between run steps minus 1
//   pc, bp_en, bp_addr: current CPU PC and breakpoint configuration
//   cpu_step          : one-clk step pulse to the CPU (registered)
//   state [2]         : IDLE=00 STEP=01 RUN=10 BREAK=11 (registered)
//   bp_hit            : sticky while stopped at a breakpoint
//   step_count [8]    : steps issued since reset, mod 256
// ----------------------------------------------------------------------------
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  step_req,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic [DIV_BITS-1:0]   rate,
    input  logic [PC_W-1:0]       pc,
    input  logic                  bp_en,
    input  logic [PC_W-1:0]       bp_addr,
    output logic                  cpu_step,
    output logic [1:0]            state,
    output logic                  bp_hit,
    output logic [STEP_CNT_W-1:0] step_count
);

    run_state_e            state_d, state_q;
    logic                  cpu_step_d, cpu_step_q;
    logic                  bp_hit_d, bp_hit_q;
    logic [STEP_CNT_W-1:0] step_count_d, step_count_q;
    // High on the clk after a RUN step: the CPU has just advanced pc, so this
    // is the only cycle where the breakpoint compare is meaningful. Starting
    // a run on the breakpoint address therefore never stops immediately.
    logic                  bp_check_d, bp_check_q;

    run_req_t req;
    run_cmd_e cmd;
    logic     div_load;
    logic     div_tick;
    logic     div_expire;
    logic     bp_match;

    assign req      = '{halt: halt_req, run: run_req, step: step_req};
    assign cmd      = resolve_cmd(req);
    assign div_tick = tick && (state_q == ST_RUN);
    assign bp_match = bp_check_q && bp_en && (pc == bp_addr);

    run_rate_divider #(
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (div_load),
        .tick_en (div_tick),
        .rate    (rate),
        .expire  (div_expire)
    );

    always_comb begin
        state_d    = state_q;
        cpu_step_d = 1'b0;
        bp_hit_d   = bp_hit_q;
        div_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // halt is a no-op here but still masks run/step.
                if (cmd == CMD_RUN) begin
                    state_d  = ST_RUN;
                    div_load = 1'b1;
                end else if (cmd == CMD_STEP) begin
                    state_d    = ST_STEP;
                    cpu_step_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                // halt outranks a coincident breakpoint match; a stop also
                // swallows a step that would have fired this tick.
                if (cmd == CMD_HALT) begin
                    state_d = ST_IDLE;
                end else if (bp_match) begin
                    state_d  = ST_BREAK;
                    bp_hit_d = 1'b1;
                end else if (div_expire) begin
                    cpu_step_d = 1'b1;
                end
            end
            ST_BREAK: begin
                if (cmd != CMD_NONE)
                    bp_hit_d = 1'b0;
                if (cmd == CMD_HALT) begin
                    state_d = ST_IDLE;
                end else if (cmd == CMD_RUN) begin
                    state_d  = ST_RUN;
                    div_load = 1'b1;
                end else if (cmd == CMD_STEP) begin
                    state_d    = ST_STEP;
                    cpu_step_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        step_count_d = cpu_step_d ? step_count_q + STEP_CNT_W'(1) : step_count_q;
        bp_check_d   = cpu_step_q && (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cpu_step_q   <= 1'b0;
            bp_hit_q     <= 1'b0;
            step_count_q <= '0;
            bp_check_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_step_q   <= cpu_step_d;
            bp_hit_q     <= bp_hit_d;
            step_count_q <= step_count_d;
            bp_check_q   <= bp_check_d;
        end
    end

    assign cpu_step   = cpu_step_q;
    assign state      = state_q;
    assign bp_hit     = bp_hit_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model. The CPU is
// emulated by advancing pc on every cpu_step pulse.
module tb_cpu_run_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick, step_req, run_req, halt_req;
    logic [3:0] rate;
    logic [2:0] pc, bp_addr;
    logic       bp_en;
    logic       cpu_step;
    logic [1:0] state;
    logic       bp_hit;
    logic [7:0] step_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode, pending-ticks-to-next-step, sticky hit, count.
    logic [1:0] m_state;
    bit         m_step, m_hit, m_prev;
    logic [7:0] m_cnt;
    int         m_left;

    cpu_run_controller #(.DIV_BITS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .step_req   (step_req),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .rate       (rate),
        .pc         (pc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_step   (cpu_step),
        .state      (state),
        .bp_hit     (bp_hit),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit h, input bit r, input bit s, input bit t);
        halt_req = h; run_req = r; step_req = s; tick = t;
    endtask

    task automatic model_reset();
        m_state = 2'b00; m_step = 0; m_hit = 0; m_prev = 0; m_cnt = 8'd0; m_left = 0;
    endtask

    // Advance one clk: predict from current inputs, clock, emulate the CPU,
    // then compare all outputs against the model.
    task automatic clk1();
        logic [1:0] ns;
        bit nstep, nhit, nprev, s;
        int nleft;
        s = cpu_step;
        ns = m_state; nstep = 0; nhit = m_hit; nleft = m_left;
        case (m_state)
            2'b00: begin
                if (halt_req) ;
                else if (run_req) begin ns = 2'b10; nleft = int'(rate) + 1; end
                else if (step_req) begin ns = 2'b01; nstep = 1; end
            end
            2'b01: ns = 2'b00;
            2'b10: begin
                if (halt_req) ns = 2'b00;
                else if (m_prev && bp_en && pc == bp_addr) begin ns = 2'b11; nhit = 1; end
                else if (tick) begin
                    nleft--;
                    if (nleft == 0) begin nstep = 1; nleft = int'(rate) + 1; end
                end
            end
            default: begin
                if (halt_req) begin ns = 2'b00; nhit = 0; end
                else if (run_req) begin ns = 2'b10; nleft = int'(rate) + 1; nhit = 0; end
                else if (step_req) begin ns = 2'b01; nstep = 1; nhit = 0; end
            end
        endcase
        nprev = m_step && (m_state == 2'b10);
        @(posedge clk);
        #1;
        if (s) pc = pc + 3'd1;
        m_state = ns; m_step = nstep; m_hit = nhit; m_left = nleft; m_prev = nprev;
        m_cnt = m_cnt + 8'(nstep);
        chk("model_state", state, m_state);
        chk("model_cpu_step", cpu_step, m_step);
        chk("model_bp_hit", bp_hit, m_hit);
        chk("model_step_count", step_count, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        pc = 3'd0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_state", state, 0);
        chk("reset_cpu_step", cpu_step, 0);
        chk("reset_bp_hit", bp_hit, 0);
        chk("reset_step_count", step_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit         h, r, s, t;
        logic [1:0] st;
        bit         stp;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int pulses;
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        rate = 4'd0; pc = 3'd0; bp_en = 1'b0; bp_addr = 3'd0;
        model_reset();
        #2;
        chk("async_reset_state", state, 0);
        chk("async_reset_count", step_count, 0);

        // Single step, priority resolution, run with rate 0, ignored requests.
        tbl[0]  = '{0, 0, 1, 0, 2'b01, 1, 8'd1};
        tbl[1]  = '{0, 0, 0, 0, 2'b00, 0, 8'd1};
        tbl[2]  = '{0, 0, 0, 0, 2'b00, 0, 8'd1};
        tbl[3]  = '{1, 1, 1, 0, 2'b00, 0, 8'd1};
        tbl[4]  = '{0, 1, 1, 0, 2'b10, 0, 8'd1};
        tbl[5]  = '{0, 0, 0, 1, 2'b10, 1, 8'd2};
        tbl[6]  = '{0, 0, 0, 0, 2'b10, 0, 8'd2};
        tbl[7]  = '{0, 0, 1, 0, 2'b10, 0, 8'd2};
        tbl[8]  = '{0, 0, 0, 1, 2'b10, 1, 8'd3};
        tbl[9]  = '{1, 0, 0, 0, 2'b00, 0, 8'd3};
        tbl[10] = '{0, 0, 0, 1, 2'b00, 0, 8'd3};
        tbl[11] = '{1, 0, 0, 0, 2'b00, 0, 8'd3};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].h, tbl[i].r, tbl[i].s, tbl[i].t);
            clk1();
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_cpu_step", i), cpu_step, tbl[i].stp);
            chk($sformatf("tbl%0d_count", i), step_count, tbl[i].cnt);
        end
        drive(0, 0, 0, 0);

        // rate=2: steps after ticks 3, 6 and 9.
        do_reset();
        rate = 4'd2;
        drive(0, 1, 0, 0); clk1(); drive(0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            tick = 1'b1; clk1(); tick = 1'b0;
            chk($sformatf("rate2_tick%0d_step", i), cpu_step, (i % 3 == 0) ? 1 : 0);
            clk1(); clk1();
        end
        chk("rate2_count", step_count, 3);
        chk("rate2_state", state, 2);

        // rate all ones: one step per 16 ticks.
        do_reset();
        rate = 4'hF;
        drive(0, 1, 0, 0); clk1(); drive(0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            tick = 1'b1; clk1(); tick = 1'b0;
            pulses += int'(cpu_step);
            clk1();
        end
        chk("rate15_pulses", pulses, 2);

        // Breakpoint at 3, pc starting at 0, rate 0.
        do_reset();
        rate = 4'd0; bp_en = 1'b1; bp_addr = 3'd3;
        drive(0, 1, 0, 0); clk1(); drive(0, 0, 0, 0);
        for (int i = 0; i < 100 && state != 2'b11; i++) begin
            tick = (i % 4 == 0); clk1();
        end
        tick = 1'b0;
        chk("bp_state", state, 3);
        chk("bp_hit", bp_hit, 1);
        chk("bp_pc", pc, 3);
        chk("bp_count", step_count, 3);

        // Resume from BREAK while still on the breakpoint address.
        drive(0, 1, 0, 0); clk1(); drive(0, 0, 0, 0);
        chk("resume_state", state, 2);
        chk("resume_bp_hit", bp_hit, 0);
        for (int i = 0; i < 50 && step_count != 8'd4; i++) begin
            tick = (i % 4 == 0); clk1();
        end
        tick = 1'b0;
        clk1(); clk1(); clk1();
        chk("resume_state_after", state, 2);
        chk("resume_pc", pc, 4);
        chk("resume_count", step_count, 4);

        // Asynchronous reset mid-RUN, between clk edges.
        rate = 4'd5;
        tick = 1'b1; clk1(); clk1(); tick = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_state", state, 0);
        chk("midrun_reset_step", cpu_step, 0);
        chk("midrun_reset_hit", bp_hit, 0);
        chk("midrun_reset_count", step_count, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; pc = 3'd0; bp_en = 1'b0;

        // 256 single steps wrap the counter.
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 1, 0); clk1();
            drive(0, 0, 0, 0); clk1();
            if (i == 254) chk("wrap_255", step_count, 255);
        end
        chk("wrap_0", step_count, 0);
        chk("wrap_state", state, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) rate = 4'($urandom_range(0, 3) == 0 ? 15 : $urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) bp_en = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bp_addr = 3'($urandom);
            clk1();
        end
        drive(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
